mem_port_arbiter: RTL

Shares the single-ported unified instruction/data memory of the pipelined RISC-V core between the fetch stage and the memory stage. Arbitrates requests, runs one memory transaction at a time, and returns read data with a one-cycle ready pulse. Produces per-port stall signals that the hazard controller ORs into its `stallF` and memory-stage stall logic. Supports discarding an in-flight fetch when fetch is flushed by a taken branch or jump.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/arb_streak_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, grant
// identity and the request bundle presented to the memory.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY
  } arb_state_e;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } arb_gnt_e;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  we;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants that overtook a waiting fetch;
// sat tells the arbiter to let the fetch through next.
module arb_streak_counter #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(MAX_STREAK + 1);

  logic [CW-1:0] count_q, count_d;

  assign sat = (count_q == CW'(MAX_STREAK));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !sat) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data
// stage: one transaction at a time, data first unless fetch has starved.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_dm
);

  arb_state_e        state_q;
  logic              memReq_q, memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q, ifRdata_q, dmRdata_q;
  logic              ifReady_q, dmReady_q, killPending_q;

  logic     ifElig, dmElig, pickIf, gntIf, gntDm, streakSat;
  arb_gnt_e gnt;
  arb_req_t winReq;

  // A port that is pulsing ready this cycle cannot re-issue, which prevents double-issue.
  assign ifElig = if_req & ~ifReady_q & ~if_kill;
  assign dmElig = dm_req & ~dmReady_q;
  assign pickIf = ifElig & (~dmElig | streakSat);
  assign gntIf  = (state_q == IDLE) & pickIf;
  assign gntDm  = (state_q == IDLE) & dmElig & ~pickIf;

  always_comb begin
    gnt    = GNT_DM;
    winReq = '{addr: ARB_ADDR_W'(dm_addr), we: dm_we, wdata: ARB_DATA_W'(dm_wdata)};
    if (pickIf) begin
      gnt    = GNT_IF;
      winReq = '{addr: ARB_ADDR_W'(if_addr), we: 1'b0, wdata: '0};
    end
  end

  arb_streak_counter #(
    .MAX_STREAK(MAX_STREAK)
  ) u_streak (
    .clk(clk),
    .rst(rst),
    .inc(gntDm & ifElig),
    .clr(gntIf | (gntDm & ~ifElig)),
    .sat(streakSat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      memReq_q      <= 1'b0;
      memWe_q       <= 1'b0;
      memAddr_q     <= '0;
      memWdata_q    <= '0;
      ifRdata_q     <= '0;
      dmRdata_q     <= '0;
      ifReady_q     <= 1'b0;
      dmReady_q     <= 1'b0;
      killPending_q <= 1'b0;
    end else begin
      ifReady_q <= 1'b0;
      dmReady_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gntIf || gntDm) begin
            state_q    <= (gnt == GNT_IF) ? IF_BUSY : DM_BUSY;
            memReq_q   <= 1'b1;
            memWe_q    <= winReq.we;
            memAddr_q  <= ADDR_W'(winReq.addr);
            memWdata_q <= DATA_W'(winReq.wdata);
          end
        end
        IF_BUSY: begin
          if (mem_ack) begin
            state_q       <= IDLE;
            memReq_q      <= 1'b0;
            killPending_q <= 1'b0;
            // A kill arriving with the ack still discards the fetch.
            if (!killPending_q && !if_kill) begin
              ifRdata_q <= mem_rdata;
              ifReady_q <= 1'b1;
            end
          end else if (if_kill) begin
            killPending_q <= 1'b1;
          end
        end
        DM_BUSY: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            memReq_q  <= 1'b0;
            dmReady_q <= 1'b1;
            if (!memWe_q) begin
              dmRdata_q <= mem_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign if_rdata  = ifRdata_q;
  assign if_ready  = ifReady_q;
  assign dm_rdata  = dmRdata_q;
  assign dm_ready  = dmReady_q;
  assign stall_if  = if_req & ~ifReady_q;
  assign stall_dm  = dm_req & ~dmReady_q;

endmodule
